// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and size decode.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_D  = 3'b011,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101,
        LSU_WU = 3'b110
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_FAULT
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(logic [2:0] funct3);
        logic [3:0] n;
        case (funct3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath: load extract/extend, sub-word store merge, and
// illegal/misaligned decode of an incoming request.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]                  dec_funct3_i,
    input  logic                        dec_is_store_i,
    input  logic [2:0]                  dec_addr_lo_i,
    input  logic [2:0]                  funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   lane_i,
    input  logic [XLEN-1:0]             word_i,
    input  logic [XLEN-1:0]             wdata_i,
    output logic [XLEN-1:0]             ld_data_o,
    output logic [XLEN-1:0]             st_data_o,
    output logic                        fault_o
);

    logic [3:0]      nbytes;
    logic [XLEN-1:0] bmask;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] shifted;
    logic            sign_bit;
    logic            illegal;
    logic            misal;

    // bmask covers the access size at lane 0; lane_mask is the same field moved to its lane.
    always_comb begin
        nbytes   = size_bytes(funct3_i);
        bmask    = '0;
        sign_bit = 1'b0;
        shifted  = word_i >> {lane_i, 3'b000};
        for (int i = 0; i < XLEN / 8; i++) begin
            if (i < int'(nbytes)) bmask[i*8 +: 8] = 8'hFF;
            if (i + 1 == int'(nbytes)) sign_bit = shifted[i*8 + 7];
        end
        lane_mask = bmask << {lane_i, 3'b000};
        ld_data_o = (shifted & bmask) | ((!funct3_i[2] && sign_bit) ? ~bmask : '0);
        st_data_o = (word_i & ~lane_mask) | ((wdata_i << {lane_i, 3'b000}) & lane_mask);
    end

    always_comb begin
        illegal = (dec_funct3_i == 3'b111) || (dec_is_store_i && dec_funct3_i[2]);
        if (XLEN == 32 && (dec_funct3_i == LSU_D || dec_funct3_i == LSU_WU)) illegal = 1'b1;
        case (dec_funct3_i[1:0])
            2'b01:   misal = dec_addr_lo_i[0];
            2'b10:   misal = |dec_addr_lo_i[1:0];
            2'b11:   misal = |dec_addr_lo_i[2:0];
            default: misal = 1'b0;
        endcase
        fault_o = illegal || misal;
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: one RISC-V access per request, sub-word stores
// done as read-modify-write, configurable memory read latency.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for req; mem_addr driven to 0
//   ST_READ  | MEM_LAT cycles on the down-counter; word captured at terminal count
//   ST_WRITE | one-cycle mem_wr with full or merged data
//   ST_DONE  | one-cycle done pulse; load result already in rdata
//   ST_FAULT | one-cycle done with misaligned set, no memory access
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            req_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            mem_wr_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int         LB      = $clog2(XLEN / 8);
    localparam int         CW      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [2:0] F3_FULL = (XLEN == 64) ? 3'(LSU_D) : 3'(LSU_W);

    lsu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] word_q;
    logic [XLEN-1:0] rdata_q;

    logic            accept;
    logic            last_read;
    logic            fault;
    logic [XLEN-1:0] align_word;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_data;

    assign accept    = (state_q == ST_IDLE) && req_i;
    assign last_read = (state_q == ST_READ) && (cnt_q == '0);
    // Bypass mem_rdata during READ so the load result is ready on entry to DONE.
    assign align_word = (state_q == ST_READ) ? mem_rdata_i : word_q;

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_align (
        .dec_funct3_i   (funct3_i),
        .dec_is_store_i (is_store_i),
        .dec_addr_lo_i  (addr_i[2:0]),
        .funct3_i       (funct3_q),
        .lane_i         (addr_q[LB-1:0]),
        .word_i         (align_word),
        .wdata_i        (wdata_q),
        .ld_data_o      (ld_data),
        .st_data_o      (st_data),
        .fault_o        (fault)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                is_store_q <= is_store_i;
                funct3_q   <= funct3_i;
                addr_q     <= addr_i;
                wdata_q    <= wdata_i;
            end
            if (last_read) begin
                word_q <= mem_rdata_i;
                if (!is_store_q) rdata_q <= ld_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (fault) begin
                        state_d = ST_FAULT;
                    end else if (is_store_i && funct3_i == F3_FULL) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = CW'(MEM_LAT - 1);
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == '0) state_d = is_store_q ? ST_WRITE : ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE) || (state_q == ST_FAULT);
    assign misaligned_o = (state_q == ST_FAULT);
    assign rdata_o      = rdata_q;
    assign mem_addr_o   = (state_q == ST_IDLE) ? '0 : {addr_q[XLEN-1:LB], {LB{1'b0}}};
    assign mem_wdata_o  = (state_q == ST_WRITE) ? st_data : '0;
    assign mem_wr_o     = (state_q == ST_WRITE) && !reset_i;

endmodule
